// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI-lite read bus (AR + R channels); master modport drives AR and rready, slave modport drives arready and the R beat
interface axi_rd_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two AXI-lite read masters (m0 IFU, m1 LSU) share one SRAM slave, one outstanding read; ports clk, rst, m0/m1 (slave side), s (master side); define ARB_ROUND_ROBIN_EN for round-robin instead of m1 priority
module axi_rd_arbiter #(
  parameter logic [31:0] IDLE_RDATA = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t      state, state_nxt;
  logic [31:0] addr;
  logic        gnt;
  logic        sel;
  logic        req;
  logic        idle_ok;
  logic        data_ok;
  logic        m0_beat;
  logic        m1_beat;
  assign req = m0.arvalid | m1.arvalid;
`ifdef ARB_ROUND_ROBIN_EN
  // last-granted master; reset to m1 so m0 wins the first tie
  logic last;
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (state == IDLE && req) last <= sel;
  assign sel = (m0.arvalid && m1.arvalid) ? ~last : m1.arvalid;
`else
  assign sel = m1.arvalid;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      gnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr <= sel ? m1.araddr : m0.araddr;
        gnt  <= sel;
      end
    end
  end
  always_comb begin
    state_nxt = (state == IDLE && req)                    ? ADDR :
                (state == ADDR && s.arready)              ? DATA :
                (state == DATA && s.rvalid && s.rready)   ? IDLE : state;
  end
  // rst gates the combinational paths so a reset cycle neither grants nor delivers a beat
  assign idle_ok    = state == IDLE && !rst;
  assign data_ok    = state == DATA && !rst;
  assign m0.arready = idle_ok && m0.arvalid && !sel;
  assign m1.arready = idle_ok && sel;
  assign s.arvalid  = state == ADDR;
  assign s.araddr   = addr;
  assign s.rready   = data_ok && (gnt ? m1.rready : m0.rready);
  assign m0_beat    = data_ok && !gnt;
  assign m1_beat    = data_ok && gnt;
  assign m0.rvalid  = m0_beat && s.rvalid;
  assign m0.rdata   = m0_beat ? s.rdata : IDLE_RDATA;
  assign m0.rresp   = m0_beat ? s.rresp : 2'b00;
  assign m1.rvalid  = m1_beat && s.rvalid;
  assign m1.rdata   = m1_beat ? s.rdata : IDLE_RDATA;
  assign m1.rresp   = m1_beat ? s.rresp : 2'b00;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter (fixed-priority or round-robin build)
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   c0, c1;
  bit   exp_w[$];
  axi_rd_arbiter_if m0_bus();
  axi_rd_arbiter_if m1_bus();
  axi_rd_arbiter_if s_bus();
  axi_rd_arbiter dut (.clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    m0_bus.araddr = '0; m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b1;
    m1_bus.araddr = '0; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b1;
    s_bus.arready = 1'b0; s_bus.rdata = '0; s_bus.rresp = 2'b00; s_bus.rvalid = 1'b0;
    rst = 1'b1;
    tick; tick;
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_0000; #1;
    chk("rst_m0_arready", m0_bus.arready, 0);
    chk("rst_s_arvalid", s_bus.arvalid, 0);
    chk("rst_s_rready", s_bus.rready, 0);
    chk("rst_m0_rvalid", m0_bus.rvalid, 0);
    rst = 1'b0; #1;
    chk("c0_m0_arready", m0_bus.arready, 1);
    chk("c0_m1_arready", m1_bus.arready, 0);
    tick;
    m0_bus.arvalid = 1'b0; s_bus.arready = 1'b1; s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0010_0093; #1;
    chk("c1_s_arvalid", s_bus.arvalid, 1);
    chk("c1_s_araddr", s_bus.araddr, 32'h8000_0000);
    chk("c1_s_rready", s_bus.rready, 0);
    chk("c1_m0_rvalid", m0_bus.rvalid, 0);
    tick;
    chk("c2_m0_rvalid", m0_bus.rvalid, 1);
    chk("c2_m0_rdata", m0_bus.rdata, 32'h0010_0093);
    chk("c2_m1_rvalid", m1_bus.rvalid, 0);
    chk("c2_m1_rdata", m1_bus.rdata, 32'h0000_0013);
    chk("c2_s_arvalid", s_bus.arvalid, 0);
    chk("c2_s_rready", s_bus.rready, 1);
    tick;
    chk("c3_m0_rvalid", m0_bus.rvalid, 0);
    chk("c3_m0_rdata", m0_bus.rdata, 32'h0000_0013);
    chk("c3_s_rready", s_bus.rready, 0);
    s_bus.rvalid = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    c0 = 4; c1 = 4;
`else
    exp_w = '{1'b1, 1'b0};
    c0 = 1; c1 = 1;
`endif
    m0_bus.araddr = 32'h0000_1000; m1_bus.araddr = 32'h0000_2000;
    for (int i = 0; i < exp_w.size(); i++) begin
      m0_bus.arvalid = c0 > 0; m1_bus.arvalid = c1 > 0; s_bus.arready = 1'b1; #1;
      chk($sformatf("arb%0d_m1_arready", i), m1_bus.arready, exp_w[i]);
      chk($sformatf("arb%0d_m0_arready", i), m0_bus.arready, !exp_w[i]);
      if (exp_w[i]) c1--; else c0--;
      tick;
      m0_bus.arvalid = c0 > 0; m1_bus.arvalid = c1 > 0; #1;
      chk($sformatf("arb%0d_s_araddr", i), s_bus.araddr, exp_w[i] ? 32'h0000_2000 : 32'h0000_1000);
      chk($sformatf("arb%0d_hold_arready", i), m0_bus.arready | m1_bus.arready, 0);
      tick;
      s_bus.rvalid = 1'b1; s_bus.rdata = i; #1;
      chk($sformatf("arb%0d_win_rvalid", i), exp_w[i] ? m1_bus.rvalid : m0_bus.rvalid, 1);
      chk($sformatf("arb%0d_lose_rvalid", i), exp_w[i] ? m0_bus.rvalid : m1_bus.rvalid, 0);
      chk($sformatf("arb%0d_win_rdata", i), exp_w[i] ? m1_bus.rdata : m0_bus.rdata, i);
      tick;
      s_bus.rvalid = 1'b0;
    end
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h0000_0004; s_bus.arready = 1'b0; #1;
    chk("st_m0_arready", m0_bus.arready, 1);
    tick;
    m0_bus.arvalid = 1'b0; m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h0000_0044;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("st_s_arvalid", s_bus.arvalid, 1);
      chk("st_s_araddr", s_bus.araddr, 32'h0000_0004);
      chk("st_m1_arready", m1_bus.arready, 0);
      chk("st_m0_arready", m0_bus.arready, 0);
      tick;
    end
    s_bus.arready = 1'b1; tick;
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_0005; #1;
    chk("st_m0_rvalid", m0_bus.rvalid, 1);
    tick;
    s_bus.rvalid = 1'b0; #1;
    chk("b2b_m1_arready", m1_bus.arready, 1);
    tick;
    m1_bus.arvalid = 1'b0; #1;
    chk("b2b_s_araddr", s_bus.araddr, 32'h0000_0044);
    tick;
    m1_bus.rready = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("rr_s_rready", s_bus.rready, 0);
      chk("rr_m1_rvalid", m1_bus.rvalid, 1);
      tick;
    end
    m1_bus.rready = 1'b1; #1;
    chk("rr_s_rready_rise", s_bus.rready, 1);
    chk("rr_m1_rdata", m1_bus.rdata, 32'hCAFE_F00D);
    tick;
    chk("rr_after_m1_rvalid", m1_bus.rvalid, 0);
    s_bus.rvalid = 1'b0;
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h0000_0008; tick;
    m0_bus.arvalid = 1'b0; tick;
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_0066; rst = 1'b1; #1;
    chk("rs_m0_rvalid", m0_bus.rvalid, 0);
    chk("rs_s_rready", s_bus.rready, 0);
    tick;
    rst = 1'b0; #1;
    chk("rs_idle_s_arvalid", s_bus.arvalid, 0);
    chk("rs_idle_m0_rvalid", m0_bus.rvalid, 0);
    chk("rs_idle_s_rready", s_bus.rready, 0);
    s_bus.rvalid = 1'b0; m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h0000_000C; #1;
    chk("rs_m0_arready", m0_bus.arready, 1);
    tick;
    m0_bus.arvalid = 1'b0; #1;
    chk("rs_s_araddr", s_bus.araddr, 32'h0000_000C);
    tick;
    s_bus.rvalid = 1'b1; s_bus.rresp = 2'b10; s_bus.rdata = 32'h0000_0077; #1;
    chk("rs_m0_rresp", m0_bus.rresp, 2'b10);
    chk("rs_m0_rdata", m0_bus.rdata, 32'h0000_0077);
    chk("rs_m1_rresp", m1_bus.rresp, 2'b00);
    tick;
    s_bus.rvalid = 1'b0; s_bus.rresp = 2'b00;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: IDLE_RDATA, default 32'h0000_0013 (NOP), rdata value driven to any master not currently receiving a read beat.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m{0,1}_araddr  input  32  master read address (m0 = IFU, m1 = LSU).
REQ-005 m{0,1}_arvalid  input  1  master read request valid.
REQ-006 m{0,1}_arready  output  1  master AR handshake accept.
REQ-007 m{0,1}_rdata / m{0,1}_rresp / m{0,1}_rvalid  output  32/2/1  read data beat routed to master.
REQ-008 m{0,1}_rready  input  1  master read data accept.
REQ-009 s_araddr / s_arvalid  output  32/1  AR channel to shared SRAM slave.
REQ-010 s_arready  input  1  slave AR accept.
REQ-011 s_rdata / s_rresp / s_rvalid  input  32/2/1  slave read beat.
REQ-012 s_rready  output  1  read beat accept to slave.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, DATA; one outstanding read total; AXI-lite single-beat only.
REQ-014 IDLE: if any mX_arvalid, winner selected per REQ-020, winner's mX_arready=1 combinationally in same cycle, winner araddr and id latched, next state ADDR; loser arready=0.
REQ-015 ADDR: s_arvalid=1, s_araddr=latched address (stable until s_arready); on s_arready=1 -> DATA; s_rready=0 in ADDR.
REQ-016 DATA: s_arvalid=0; granted master gets rvalid=s_rvalid, rdata=s_rdata, rresp=s_rresp; s_rready=granted mX_rready; on s_rvalid&&s_rready -> IDLE.
REQ-017 Non-granted master, and all masters outside DATA: rvalid=0, rresp=2'b00, rdata=IDLE_RDATA.
REQ-018 mX_arready SHALL be 0 in ADDR and DATA; requests arriving then wait, arvalid held by master per AXI.
REQ-019 Minimum latency: AR accept (cycle 0) -> s_arvalid cycle 1 -> earliest R beat to master cycle 2 if slave accepts AR in cycle 1 and rvalid in cycle 2.
REQ-020 Arbitration: with no macro, fixed priority m1 over m0 on simultaneous arvalid; single requester always wins.
REQ-021 s_rvalid while not in DATA SHALL be ignored (s_rready=0, nothing routed).
REQ-022 Back-to-back: DATA completion -> IDLE for one cycle minimum before next grant; no request dropped.
REQ-023 rresp forwarded unchanged including SLVERR/DECERR; arbiter SHALL not retry.

Reset
REQ-024 rst=1 at clk edge: state=IDLE, latched address=0, grant id=0, round-robin pointer=last-granted m1; outputs same cycle-after values: all arready/arvalid/rvalid/rready 0 except combinational IDLE arready per REQ-014 once rst=0.
REQ-025 rst asserted mid-transaction SHALL abandon it: next cycle IDLE, s_arvalid=0, s_rready=0, no beat delivered to any master.
REQ-026 While rst=1 all mX_arready SHALL be 0.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN: defined -> round-robin, on simultaneous requests the master not granted last wins, pointer updated at each IDLE grant; undefined -> fixed priority per REQ-020, pointer logic absent.

Verification
REQ-028 Single m0 read 0x8000_0000, slave arready=1 immediately, rdata 0x00100093 next cycle -> m0_rvalid with 0x00100093 at cycle 2, m1_rvalid=0, m1_rdata=0x13.
REQ-029 m0 and m1 arvalid same cycle, no macro -> m1 granted first, m0 granted in IDLE after m1 beat completes; with ARB_ROUND_ROBIN_EN after reset -> m0 first, then m1, then alternating over 4 requests each.
REQ-030 Slave holds s_arready=0 for 3 cycles -> s_arvalid and s_araddr stable all 3 cycles, no arready to either master.
REQ-031 Master m1_rready=0 for 2 cycles while s_rvalid=1 -> s_rready=0, state held DATA, beat delivered on cycle rready rises.
REQ-032 rst pulsed in DATA with s_rvalid=1 -> no master rvalid, next cycle IDLE, new m0 request then completes normally; s_rresp=2'b10 on later read -> m0_rresp=2'b10.
